// File: rtl/mem_store_buf.sv
// Store buffer between the memory stage and the data-memory write port.
// Aligns stores onto 8-byte beats, drains in order, supports fences.
module mem_store_buf #(
   parameter int DEPTH = 4,
   parameter int AW    = 64,
   parameter int DW    = 64
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_data,
   input  logic [1:0]    req_size,
   output logic          mem_wen,
   output logic [AW-1:0] mem_waddr,
   output logic [DW-1:0] mem_wdata,
   output logic [7:0]    mem_wmask,
   input  logic          mem_wready,
   input  logic [AW-1:0] ld_addr,
   output logic          ld_hit,
   input  logic          fence,
   output logic          fence_done,
   output logic          err_misaligned,
   output logic          busy
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [AW-1:0] BEAT_MASK = AW'(64'h0000_0000_7fff_fff8);

   typedef enum logic {S_IDLE, S_FENCE} state_e;

   state_e        state_q, state_d;
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic          err_q;

   logic [AW-1:0] addr_q [DEPTH];
   logic [DW-1:0] data_q [DEPTH];
   logic [7:0]    mask_q [DEPTH];

   logic [2:0]    off;
   logic          misal;
   logic          accept;
   logic          push;
   logic          pop;
   logic [AW-1:0] new_addr;
   logic [DW-1:0] new_data;
   logic [DW-1:0] data_sz;
   logic [7:0]    mask_sz;

   assign off      = req_addr[2:0];
   assign new_addr = req_addr & BEAT_MASK;
   assign new_data = data_sz << {off, 3'b000};

   always_comb begin
      data_sz = '0;
      mask_sz = 8'h00;
      misal   = 1'b0;
      case (req_size)
         2'd0: begin
            data_sz = {{(DW-8){1'b0}}, req_data[7:0]};
            mask_sz = 8'h01;
         end
         2'd1: begin
            data_sz = {{(DW-16){1'b0}}, req_data[15:0]};
            mask_sz = 8'h03;
            misal   = off[0];
         end
         2'd2: begin
            data_sz = {{(DW-32){1'b0}}, req_data[31:0]};
            mask_sz = 8'h0f;
            misal   = |off[1:0];
         end
         default: begin
            data_sz = req_data;
            mask_sz = 8'hff;
            misal   = |off;
         end
      endcase
   end

   assign accept = req_valid && req_ready;
   assign push   = accept && !misal;
   assign pop    = mem_wen && mem_wready;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
            mask_q[i] <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         err_q   <= accept && misal;
         if (push) begin
            addr_q[tail_q] <= new_addr;
            data_q[tail_q] <= new_data;
            mask_q[tail_q] <= mask_sz << off;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (fence) state_d = S_FENCE;
         S_FENCE: if (count_q == '0) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready  = (count_q != CW'(DEPTH)) && (state_q == S_IDLE);
      fence_done = (state_q == S_FENCE) && (count_q == '0);
   end

   // Entry i is live when its distance from head is below count.
   always_comb begin
      ld_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (({1'b0, PW'(i) - head_q} < count_q) &&
             (addr_q[i] == (ld_addr & BEAT_MASK)))
            ld_hit = 1'b1;
      end
   end

   assign mem_wen        = (count_q != '0);
   assign busy           = (count_q != '0);
   assign mem_waddr      = addr_q[head_q];
   assign mem_wdata      = data_q[head_q];
   assign mem_wmask      = mask_q[head_q];
   assign err_misaligned = err_q;

endmodule

// File: tb/tb_mem_store_buf.sv
// Scoreboard bench for mem_store_buf: directed stores,
// hazard, fence and reset scenarios.
module tb_mem_store_buf;

   logic        clock;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] req_addr;
   logic [63:0] req_data;
   logic [1:0]  req_size;
   logic        mem_wen;
   logic [63:0] mem_waddr;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_wmask;
   logic        mem_wready;
   logic [63:0] ld_addr;
   logic        ld_hit;
   logic        fence;
   logic        fence_done;
   logic        err_misaligned;
   logic        busy;

   int checks = 0;
   int errors = 0;
   logic [135:0] expq [$];

   mem_store_buf #(.DEPTH(4), .AW(64), .DW(64)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_addr       (req_addr),
      .req_data       (req_data),
      .req_size       (req_size),
      .mem_wen        (mem_wen),
      .mem_waddr      (mem_waddr),
      .mem_wdata      (mem_wdata),
      .mem_wmask      (mem_wmask),
      .mem_wready     (mem_wready),
      .ld_addr        (ld_addr),
      .ld_hit         (ld_hit),
      .fence          (fence),
      .fence_done     (fence_done),
      .err_misaligned (err_misaligned),
      .busy           (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Monitor: a beat is consumed at the next rising edge.
   always @(negedge clock) begin
      if (reset_n && mem_wen && mem_wready) begin
         checks++;
         if (expq.size() == 0) begin
            errors++;
            $display("FAIL beat_unexpected act=%h_%h_%h exp=none",
                     mem_waddr, mem_wdata, mem_wmask);
         end else begin
            logic [135:0] e;
            e = expq.pop_front();
            if ({mem_waddr, mem_wdata, mem_wmask} !== e) begin
               errors++;
               $display("FAIL beat act=%h_%h_%h exp=%h_%h_%h",
                        mem_waddr, mem_wdata, mem_wmask,
                        e[135:72], e[71:8], e[7:0]);
            end
         end
      end
   end

   task automatic issue(input logic [63:0] a, input logic [63:0] d,
                        input logic [1:0] sz, input bit en,
                        input logic [63:0] ea, input logic [63:0] ed,
                        input logic [7:0] em);
      int n;
      req_valid = 1'b1;
      req_addr  = a;
      req_data  = d;
      req_size  = sz;
      n = 0;
      while (!req_ready && n < 50) begin
         step();
         n++;
      end
      if (!req_ready) begin
         checks++;
         errors++;
         $display("FAIL issue_ready act=0 exp=1");
      end
      if (en) expq.push_back({ea, ed, em});
      step();
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      mem_wready = 1'b1;
      n = 0;
      while (busy && n < 40) begin
         step();
         n++;
      end
      chk("drain_busy", 64'(busy), 64'd0);
   endtask

   initial begin
      int n;
      bit seen;
      reset_n    = 1'b0;
      req_valid  = 1'b0;
      req_addr   = '0;
      req_data   = '0;
      req_size   = '0;
      mem_wready = 1'b0;
      ld_addr    = '0;
      fence      = 1'b0;
      step();
      step();
      reset_n = 1'b1;
      step();

      chk("rst_wen",   64'(mem_wen), 64'd0);
      chk("rst_busy",  64'(busy), 64'd0);
      chk("rst_waddr", mem_waddr, 64'd0);
      chk("rst_wdata", mem_wdata, 64'd0);
      chk("rst_wmask", 64'(mem_wmask), 64'd0);
      chk("rst_fdone", 64'(fence_done), 64'd0);
      chk("rst_err",   64'(err_misaligned), 64'd0);
      chk("rst_ldhit", 64'(ld_hit), 64'd0);
      chk("rst_ready", 64'(req_ready), 64'd1);

      // sb, upper data bits must be cleared
      issue(64'h8000_0005, 64'h1234_5678_9abc_deab, 2'd0, 1'b1,
            64'h0, 64'h0000_ab00_0000_0000, 8'h20);
      chk("sb_wen",   64'(mem_wen), 64'd1);
      chk("sb_waddr", mem_waddr, 64'h0);
      chk("sb_wdata", mem_wdata, 64'h0000_ab00_0000_0000);
      chk("sb_wmask", 64'(mem_wmask), 64'h20);
      drain();

      // misaligned sw
      issue(64'h8000_0106, 64'hcafe_f00d, 2'd2, 1'b0, 0, 0, 0);
      chk("mis_err",  64'(err_misaligned), 64'd1);
      chk("mis_busy", 64'(busy), 64'd0);
      step();
      chk("mis_err_clr", 64'(err_misaligned), 64'd0);
      chk("mis_busy2",   64'(busy), 64'd0);

      // fill with sd stores while the port stalls
      mem_wready = 1'b0;
      for (int i = 0; i < 4; i++)
         issue(64'h8000_0100 + 64'(8 * i), 64'h1111_0000_0000_0000 + 64'(i),
               2'd3, 1'b1, 64'h100 + 64'(8 * i),
               64'h1111_0000_0000_0000 + 64'(i), 8'hff);
      chk("full_ready", 64'(req_ready), 64'd0);
      chk("full_busy",  64'(busy), 64'd1);
      req_valid  = 1'b1;
      req_addr   = 64'h8000_0120;
      req_data   = 64'h5555_aaaa_5555_aaaa;
      req_size   = 2'd3;
      mem_wready = 1'b1;
      expq.push_back({64'h120, 64'h5555_aaaa_5555_aaaa, 8'hff});
      step();
      chk("fifth_ready", 64'(req_ready), 64'd1);
      step();
      req_valid = 1'b0;
      drain();

      // load hazard
      mem_wready = 1'b0;
      issue(64'h8000_0012, 64'hffff_1234, 2'd1, 1'b1,
            64'h10, 64'h0000_0000_1234_0000, 8'h0c);
      ld_addr = 64'h8000_0010;
      #1;
      chk("ldhit_same", 64'(ld_hit), 64'd1);
      ld_addr = 64'h8000_0018;
      #1;
      chk("ldhit_next", 64'(ld_hit), 64'd0);
      drain();

      // fence with pending stores
      mem_wready = 1'b0;
      issue(64'h20, 64'h11, 2'd0, 1'b1, 64'h20, 64'h11, 8'h01);
      issue(64'h22, 64'h2233, 2'd1, 1'b1,
            64'h20, 64'h0000_0000_2233_0000, 8'h0c);
      issue(64'h2c, 64'hdead_beef, 2'd2, 1'b1,
            64'h28, 64'hdead_beef_0000_0000, 8'hf0);
      fence = 1'b1;
      step();
      fence      = 1'b0;
      mem_wready = 1'b1;
      seen = 1'b0;
      n = 0;
      while (!seen && n < 20) begin
         chk("fence_ready", 64'(req_ready), 64'd0);
         if (fence_done) begin
            seen = 1'b1;
            chk("fence_done_busy", 64'(busy), 64'd0);
         end else begin
            step();
            n++;
         end
      end
      chk("fence_seen", 64'(seen), 64'd1);
      step();
      chk("fence_done_clr", 64'(fence_done), 64'd0);
      chk("fence_ready_back", 64'(req_ready), 64'd1);

      // fence on empty buffer
      fence = 1'b1;
      step();
      fence = 1'b0;
      chk("efence_done",  64'(fence_done), 64'd1);
      chk("efence_ready", 64'(req_ready), 64'd0);
      step();
      chk("efence_clr",   64'(fence_done), 64'd0);
      chk("efence_ready2", 64'(req_ready), 64'd1);

      // reset in the middle of a drain
      mem_wready = 1'b0;
      issue(64'h8000_0040, 64'h0102_0304_0506_0708, 2'd3, 1'b1,
            64'h40, 64'h0102_0304_0506_0708, 8'hff);
      issue(64'h8000_0048, 64'h0a0b_0c0d_0e0f_1011, 2'd3, 1'b1,
            64'h48, 64'h0a0b_0c0d_0e0f_1011, 8'hff);
      mem_wready = 1'b1;
      step();
      chk("mid_busy", 64'(busy), 64'd1);
      reset_n = 1'b0;
      #1;
      chk("arst_wen",  64'(mem_wen), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      expq.delete();
      step();
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("post_rst_wen", 64'(mem_wen), 64'd0);
      end
      chk("post_rst_waddr", mem_waddr, 64'd0);
      chk("post_rst_wmask", 64'(mem_wmask), 64'd0);

      chk("sb_empty", 64'(expq.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_store_buf.md
Name: mem_store_buf

Overview:
- Write-side counterpart of the instruction-fetch read path.
- Accepts store requests from the memory stage through a valid/ready handshake and buffers them in a small FIFO.
- Aligns each store onto an 8-byte memory beat with a byte mask, then drains entries in order to the data-memory write port.
- Provides a load-hazard check against pending stores and a fence drain for `fence` / MMIO ordering.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- AW, 64, address width.
- DW, 64, data width; fixed at 64 because the mask is 8 bits.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  store request valid.
- req_ready  out  1  buffer can accept a store this cycle.
- req_addr  in  AW  byte address of the store.
- req_data  in  DW  store data, right-justified.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword.
- mem_wen  out  1  write beat valid.
- mem_waddr  out  AW  8-byte-aligned, masked address.
- mem_wdata  out  DW  lane-shifted data.
- mem_wmask  out  8  byte enables.
- mem_wready  in  1  memory accepts the beat this cycle.
- ld_addr  in  AW  address of the load in flight.
- ld_hit  out  1  a pending store overlaps the 8-byte beat of ld_addr.
- fence  in  1  request a full drain.
- fence_done  out  1  one-cycle pulse when a fence completes.
- err_misaligned  out  1  one-cycle pulse when a store is dropped as misaligned.
- busy  out  1  FIFO not empty.

Behaviour:
- Reset (asserted asynchronously, released synchronously):
  - FIFO emptied; head and tail pointers and count cleared; FSM returns to IDLE.
  - Outputs mem_wen, mem_waddr, mem_wdata, mem_wmask, fence_done, err_misaligned, busy and ld_hit are all 0.
  - Reset during a beat abandons it; there is no partial-write guarantee.
- Address formation:
  - Masked address: m = req_addr & 64'h0000_0000_7fff_ffff.
  - mem_waddr = {m[AW-1:3], 3'b000}.
  - Offset o = req_addr[2:0].
- Byte mask by size: byte = 8'h01, half = 8'h03, word = 8'h0f, dword = 8'hff. The mask is shifted left by o.
- Data: mem_wdata = (req_data with bits above the size cleared) << (8*o).
- Misalignment check: the store is misaligned when o is not a multiple of (1 << req_size).
  - The store is still handshaken (req_ready is honoured).
  - It is not enqueued.
  - err_misaligned pulses in the next cycle.
- Enqueue:
  - Occurs when req_valid && req_ready && aligned; the aligned entry is written at the tail.
  - req_ready = (count != DEPTH) && (state == IDLE).
  - No full-FIFO pass-through: a store presented while full waits even if the head drains in the same cycle.
- Dequeue:
  - mem_wen = (count != 0); mem_waddr, mem_wdata and mem_wmask always show the head entry.
  - The head is popped on mem_wen && mem_wready.
  - Head fields stay stable while mem_wen && !mem_wready.
- Latency: a store accepted at edge N is on the memory port from cycle N+1 when the FIFO was empty; there is no combinational bypass.
- Simultaneous enqueue and dequeue with count not full and not 0: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- ld_hit:
  - Combinational: OR over valid entries of (entry waddr == {(ld_addr & 64'h7fff_ffff)[AW-1:3], 3'b000}).
  - An entry being popped this cycle still counts.
- busy = (count != 0).
- FSM:
  - IDLE -> FENCE when fence = 1.
  - FENCE: req_ready is 0.
  - FENCE -> IDLE when count == 0; fence_done pulses on that transition.
  - fence asserted with an empty FIFO: go to FENCE, then fence_done in the following cycle.
  - fence held or re-asserted while in FENCE is ignored.

Test Plan:
- After reset, sb addr=0x8000_0005, data=0xAB -> next cycle: mem_wen=1, waddr=0x0000_0000_0000_0000, wdata=0x0000_AB00_0000_0000, wmask=0x20.
- sw addr=0x8000_0106 -> handshake completes, nothing enqueued, err_misaligned pulses one cycle, busy stays 0.
- mem_wready held at 0, issue 5 back-to-back sd stores:
  - req_ready drops after 4 stores and busy=1.
  - Releasing mem_wready drains the beats in order, one per cycle.
  - The 5th store is accepted the cycle after count falls to 3.
- With sh addr=0x8000_0012 pending, ld_addr=0x8000_0010 -> ld_hit=1; ld_addr=0x8000_0018 -> ld_hit=0.
- 3 stores pending, pulse fence, mem_wready=1 -> req_ready=0 throughout, fence_done pulses in the cycle count reaches 0, then req_ready returns to 1.
- Assert reset_n=0 mid-drain with 2 entries pending -> mem_wen and busy go to 0 immediately (asynchronously); after release, no stale beat appears.
